// File: rtl/dp_ram_pkg.sv
// Shared types and helpers for the byte-enabled dual-port RAM.
//   rdw_mode_e  : read-during-write behaviour (old data or post-write data)
//   clr_state_e : states of the post-reset clear sequencer
//   lanes()     : number of byte-enable lanes in a word
package dp_ram_pkg;

  typedef enum logic {
    RDW_READ_FIRST  = 1'b0,
    RDW_WRITE_FIRST = 1'b1
  } rdw_mode_e;

  typedef enum logic {
    CLR_IDLE  = 1'b0,
    CLR_CLEAR = 1'b1
  } clr_state_e;

  function automatic int unsigned lanes(input int unsigned width, input int unsigned byte_w);
    return width / byte_w;
  endfunction

endpackage

// File: rtl/dp_ram_rd_pipe.sv
// Read-return pipeline for one RAM port: 1 or 2 register stages.
//   clk, rst : clock and synchronous active-high reset
//   rd_data  : raw read data for the access presented this cycle
//   accept   : the port's access was accepted this cycle
//   q, qv    : registered read data and its single-cycle valid
// Data registers load only with a valid access, so q holds between accesses.
// Reset zeroes data and valid so q reads zero straight after reset.
module dp_ram_rd_pipe #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rd_data,
  input  logic             accept,
  output logic [WIDTH-1:0] q,
  output logic             qv
);

  logic [WIDTH-1:0] s1_q;
  logic             s1_v;

  // First stage: capture every accepted access.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s1_v <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) s1_q <= rd_data;
    end
  end

  if (RD_LATENCY >= 2) begin : g_lat2
    // Extra output stage; data moves only with its valid to keep them aligned.
    always_ff @(posedge clk) begin
      if (rst) begin
        q  <= '0;
        qv <= 1'b0;
      end else begin
        qv <= s1_v;
        if (s1_v) q <= s1_q;
      end
    end
  end else begin : g_lat1
    assign q  = s1_q;
    assign qv = s1_v;
  end

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with per-lane byte enables, selectable read-during-write
// mode, 1/2-cycle read latency and optional zero-fill after reset.
//   clk, rst             : single clock, synchronous active-high reset
//   en/we/be/addr/d _a,_b : per-port access request, write qualifier, lane
//                          enables, word address and write data
//   q/qv _a,_b           : per-port read data and single-cycle valid
//   busy                 : clear sequence running, all accesses ignored
//   collision            : both ports wrote the same address last cycle
module dual_port_ram_be
  import dp_ram_pkg::*;
#(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned BYTE_W       = 8,
  parameter int unsigned DEPTH        = 256,
  parameter int unsigned RD_LATENCY   = 1,
  parameter int unsigned RDW_MODE     = 0,
  parameter int unsigned CLEAR_ON_RST = 1,
  localparam int unsigned LANES       = lanes(WIDTH, BYTE_W),
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_a,
  input  logic             we_a,
  input  logic [LANES-1:0] be_a,
  input  logic [AW-1:0]    addr_a,
  input  logic [WIDTH-1:0] d_a,
  output logic [WIDTH-1:0] q_a,
  output logic             qv_a,
  input  logic             en_b,
  input  logic             we_b,
  input  logic [LANES-1:0] be_b,
  input  logic [AW-1:0]    addr_b,
  input  logic [WIDTH-1:0] d_b,
  output logic [WIDTH-1:0] q_b,
  output logic             qv_b,
  output logic             busy,
  output logic             collision
);

  localparam rdw_mode_e   MODE    = (RDW_MODE == 1) ? RDW_WRITE_FIRST : RDW_READ_FIRST;
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  clr_state_e       state;
  logic [AW-1:0]    clr_cnt;
  logic             acc_a, acc_b, in_a, in_b, same_addr;
  logic [LANES-1:0] wl_a, wl_b;
  logic [WIDTH-1:0] rd_a, rd_b;

  // Accepted accesses and the lanes each port actually writes.
  // On a shared address port A keeps its lanes; B only fills the rest.
  assign acc_a     = en_a & ~busy & ~rst;
  assign acc_b     = en_b & ~busy & ~rst;
  assign in_a      = {1'b0, addr_a} < DEPTH_X;
  assign in_b      = {1'b0, addr_b} < DEPTH_X;
  assign same_addr = (addr_a == addr_b);
  assign wl_a      = (acc_a & we_a & in_a) ? be_a : '0;
  assign wl_b      = (acc_b & we_b & in_b) ? (be_b & ~(same_addr ? wl_a : '0)) : '0;

  // Overlay this cycle's (already arbitrated) writes onto a word read at ra.
  function automatic logic [WIDTH-1:0] post_write(
    input logic [WIDTH-1:0] old,  input logic [AW-1:0]    ra,
    input logic [LANES-1:0] la,   input logic [AW-1:0]    aa,
    input logic [WIDTH-1:0] da,   input logic [LANES-1:0] lb,
    input logic [AW-1:0]    ab,   input logic [WIDTH-1:0] db);
    logic [WIDTH-1:0] r;
    r = old;
    for (int i = 0; i < LANES; i++) begin
      if (la[i] && (ra == aa))      r[i*BYTE_W +: BYTE_W] = da[i*BYTE_W +: BYTE_W];
      else if (lb[i] && (ra == ab)) r[i*BYTE_W +: BYTE_W] = db[i*BYTE_W +: BYTE_W];
    end
    return r;
  endfunction

  // Raw read data; out-of-range addresses read as zero.
  always_comb begin
    rd_a = '0;
    rd_b = '0;
    if (in_a) rd_a = mem[addr_a];
    if (in_b) rd_b = mem[addr_b];
    if (MODE == RDW_WRITE_FIRST) begin
      rd_a = post_write(rd_a, addr_a, wl_a, addr_a, d_a, wl_b, addr_b, d_b);
      rd_b = post_write(rd_b, addr_b, wl_a, addr_a, d_a, wl_b, addr_b, d_b);
    end
  end

  // Array update: clear walk or lane-masked port writes (never both at once).
  always_ff @(posedge clk) begin
    if ((state == CLR_CLEAR) && !rst) mem[clr_cnt] <= '0;
    for (int i = 0; i < LANES; i++) begin
      if (wl_a[i]) mem[addr_a][i*BYTE_W +: BYTE_W] <= d_a[i*BYTE_W +: BYTE_W];
      if (wl_b[i]) mem[addr_b][i*BYTE_W +: BYTE_W] <= d_b[i*BYTE_W +: BYTE_W];
    end
  end

  // Clear sequencer: one address per cycle, busy until the last one is written.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= (CLEAR_ON_RST != 0) ? CLR_CLEAR : CLR_IDLE;
      busy    <= (CLEAR_ON_RST != 0);
      clr_cnt <= '0;
    end else begin
      case (state)
        CLR_IDLE: busy <= 1'b0;
        CLR_CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == AW'(DEPTH - 1)) begin
            state <= CLR_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= CLR_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Same-address write from both ports, regardless of lane overlap.
  always_ff @(posedge clk) begin
    if (rst) collision <= 1'b0;
    else     collision <= acc_a & we_a & in_a & acc_b & we_b & in_b & same_addr;
  end

  dp_ram_rd_pipe #(.WIDTH(WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_a (
    .clk(clk), .rst(rst), .rd_data(rd_a), .accept(acc_a), .q(q_a), .qv(qv_a)
  );

  dp_ram_rd_pipe #(.WIDTH(WIDTH), .RD_LATENCY(RD_LATENCY)) u_pipe_b (
    .clk(clk), .rst(rst), .rd_data(rd_b), .accept(acc_b), .q(q_b), .qv(qv_b)
  );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Bench for dual_port_ram_be: two instances share one stimulus stream,
// u_rf (latency 1, read-first) and u_wf (latency 2, write-first), DEPTH=16.
module tb_dual_port_ram_be;

  logic        clk, rst;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b, addr_a, addr_b;
  logic [31:0] d_a, d_b;
  logic [31:0] q0_a, q0_b, q1_a, q1_b;
  logic        qv0_a, qv0_b, qv1_a, qv1_b, busy0, busy1, coll0, coll1;

  int n_cmp, n_fail;

  // Reference model state: word array, remaining clear cycles, expected outputs.
  logic [31:0]  mm [16];
  int           clear_left;
  logic         p_acc_a, p_acc_b;
  logic [31:0]  p_wf_a, p_wf_b;
  logic [31:0]  e0_q_a, e0_q_b, e1_q_a, e1_q_b;
  logic         e0_v_a, e0_v_b, e1_v_a, e1_v_b, e_busy, e_coll;
  logic [135:0] exp_vec;

  wire [135:0] obs = {q0_a, qv0_a, q0_b, qv0_b, busy0, coll0,
                      q1_a, qv1_a, q1_b, qv1_b, busy1, coll1};

  dual_port_ram_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .RD_LATENCY(1),
                     .RDW_MODE(0), .CLEAR_ON_RST(1)) u_rf (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .d_a(d_a), .q_a(q0_a), .qv_a(qv0_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .d_b(d_b), .q_b(q0_b), .qv_b(qv0_b),
    .busy(busy0), .collision(coll0)
  );

  dual_port_ram_be #(.WIDTH(32), .BYTE_W(8), .DEPTH(16), .RD_LATENCY(2),
                     .RDW_MODE(1), .CLEAR_ON_RST(1)) u_wf (
    .clk(clk), .rst(rst),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .d_a(d_a), .q_a(q1_a), .qv_a(qv1_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .d_b(d_b), .q_b(q1_b), .qv_b(qv1_b),
    .busy(busy1), .collision(coll1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic idle();
    en_a = 0; we_a = 0; be_a = '0; addr_a = '0; d_a = '0;
    en_b = 0; we_b = 0; be_b = '0; addr_b = '0; d_b = '0;
  endtask

  task automatic port_a(input logic we, input logic [3:0] be, input logic [3:0] ad, input logic [31:0] d);
    en_a = 1; we_a = we; be_a = be; addr_a = ad; d_a = d;
  endtask

  task automatic port_b(input logic we, input logic [3:0] be, input logic [3:0] ad, input logic [31:0] d);
    en_b = 1; we_b = we; be_b = be; addr_b = ad; d_b = d;
  endtask

  // Advance one clock: update the model from the current inputs, then sample.
  task automatic step();
    logic [31:0] nm [16];
    logic        acc_a, acc_b, coll;
    logic [31:0] rf_a, rf_b, wf_a, wf_b;
    acc_a = en_a && !rst && (clear_left == 0);
    acc_b = en_b && !rst && (clear_left == 0);
    nm = mm;
    // Apply B first, then A on top: A wins any lane both ports write.
    if (acc_b && we_b) for (int i = 0; i < 4; i++) if (be_b[i]) nm[addr_b][8*i +: 8] = d_b[8*i +: 8];
    if (acc_a && we_a) for (int i = 0; i < 4; i++) if (be_a[i]) nm[addr_a][8*i +: 8] = d_a[8*i +: 8];
    rf_a = mm[addr_a]; rf_b = mm[addr_b];
    wf_a = nm[addr_a]; wf_b = nm[addr_b];
    coll = acc_a && acc_b && we_a && we_b && (addr_a == addr_b);
    if (rst) clear_left = 16;
    else if (clear_left > 0) begin
      nm[16 - clear_left] = '0;
      clear_left--;
    end
    mm = nm;
    @(posedge clk);
    #1;
    if (rst) begin
      e0_q_a = '0; e0_q_b = '0; e1_q_a = '0; e1_q_b = '0;
      e0_v_a = 0; e0_v_b = 0; e1_v_a = 0; e1_v_b = 0;
      p_acc_a = 0; p_acc_b = 0; e_coll = 0;
    end else begin
      e0_v_a = acc_a; if (acc_a) e0_q_a = rf_a;
      e0_v_b = acc_b; if (acc_b) e0_q_b = rf_b;
      e1_v_a = p_acc_a; if (p_acc_a) e1_q_a = p_wf_a;
      e1_v_b = p_acc_b; if (p_acc_b) e1_q_b = p_wf_b;
      p_acc_a = acc_a; p_wf_a = wf_a;
      p_acc_b = acc_b; p_wf_b = wf_b;
      e_coll = coll;
    end
    e_busy = (clear_left > 0);
    exp_vec = {e0_q_a, e0_v_a, e0_q_b, e0_v_b, e_busy, e_coll,
               e1_q_a, e1_v_a, e1_q_b, e1_v_b, e_busy, e_coll};
  endtask

  task automatic test_reset();
    int n;
    idle(); rst = 1; port_a(0, 4'h0, 4'd5, '0);
    step();
    n_cmp++; if (obs !== exp_vec) begin n_fail++; $display("FAIL reset_model: got %h expected %h", obs, exp_vec); end
    n_cmp++; if ({busy0, qv0_a, q0_a, coll0, busy1, qv1_a, q1_a} !== {1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0}) begin
      n_fail++; $display("FAIL reset_state: busy=%b qv=%b q=%h coll=%b expected busy=1 qv=0 q=0 coll=0", busy0, qv0_a, q0_a, coll0);
    end
    rst = 0; n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      step(); n++;
      n_cmp++; if (obs !== exp_vec) begin n_fail++; $display("FAIL clear_walk: got %h expected %h", obs, exp_vec); end
    end
    n_cmp++; if (n != 16) begin n_fail++; $display("FAIL busy_length: got %0d cycles expected 16", n); end
    step();
    n_cmp++; if ({qv0_a, q0_a} !== {1'b1, 32'h0}) begin
      n_fail++; $display("FAIL first_read: qv=%b q=%h expected qv=1 q=00000000", qv0_a, q0_a);
    end
    idle(); step();
  endtask

  task automatic test_byte_enable();
    idle(); port_a(1, 4'b0101, 4'd3, 32'hDEADBEEF);
    step();
    n_cmp++; if ({qv0_a, q0_a} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL be_write_return: qv=%b q=%h expected 1/00000000", qv0_a, q0_a); end
    port_a(0, 4'h0, 4'd3, '0);
    step();
    n_cmp++; if ({qv0_a, q0_a} !== {1'b1, 32'h00AD00EF}) begin n_fail++; $display("FAIL be_read: qv=%b q=%h expected 1/00ad00ef", qv0_a, q0_a); end
    n_cmp++; if ({qv1_a, q1_a} !== {1'b1, 32'h00AD00EF}) begin n_fail++; $display("FAIL be_write_first_return: qv=%b q=%h expected 1/00ad00ef", qv1_a, q1_a); end
    port_a(1, 4'b0000, 4'd3, 32'hFFFFFFFF);
    step();
    n_cmp++; if (obs !== exp_vec) begin n_fail++; $display("FAIL be_noop_write: got %h expected %h", obs, exp_vec); end
    idle();
    step();
    n_cmp++; if ({qv0_a, q0_a, qv1_a, q1_a} !== {1'b0, 32'h00AD00EF, 1'b1, 32'h00AD00EF}) begin
      n_fail++; $display("FAIL be_hold: qv0=%b q0=%h qv1=%b q1=%h expected 0/00ad00ef 1/00ad00ef", qv0_a, q0_a, qv1_a, q1_a);
    end
    port_a(0, 4'h0, 4'd3, '0);
    step();
    n_cmp++; if ({qv0_a, q0_a} !== {1'b1, 32'h00AD00EF}) begin n_fail++; $display("FAIL be_noop_preserved: qv=%b q=%h expected 1/00ad00ef", qv0_a, q0_a); end
    idle(); step();
  endtask

  task automatic test_collision();
    idle(); port_a(1, 4'b0011, 4'd7, 32'h11111111); port_b(1, 4'b1111, 4'd7, 32'h22222222);
    step();
    n_cmp++; if ({coll0, coll1} !== 2'b11) begin n_fail++; $display("FAIL coll_pulse: got %b%b expected 11", coll0, coll1); end
    idle(); port_a(1, 4'b0011, 4'd8, 32'h00003344); port_b(1, 4'b1100, 4'd8, 32'h55660000);
    step();
    n_cmp++; if ({coll0, coll1} !== 2'b11) begin n_fail++; $display("FAIL coll_disjoint: got %b%b expected 11", coll0, coll1); end
    idle(); port_a(1, 4'hF, 4'd9, 32'h01020304); port_b(0, 4'h0, 4'd9, '0);
    step();
    n_cmp++; if ({coll0, coll1} !== 2'b00) begin n_fail++; $display("FAIL coll_read_write: got %b%b expected 00", coll0, coll1); end
    idle(); port_a(0, 4'h0, 4'd7, '0); port_b(0, 4'h0, 4'd8, '0);
    step();
    n_cmp++; if ({q0_a, q0_b} !== {32'h22221111, 32'h55663344}) begin
      n_fail++; $display("FAIL coll_merge: q_a=%h q_b=%h expected 22221111 55663344", q0_a, q0_b);
    end
    n_cmp++; if (obs !== exp_vec) begin n_fail++; $display("FAIL coll_model: got %h expected %h", obs, exp_vec); end
    idle(); step();
  endtask

  task automatic test_rdw();
    idle(); port_a(1, 4'hF, 4'd2, 32'hAAAAAAAA);
    step();
    port_a(0, 4'h0, 4'd2, '0); port_b(1, 4'hF, 4'd2, 32'h55555555);
    step();
    n_cmp++; if ({q0_a, q0_b} !== {32'hAAAAAAAA, 32'hAAAAAAAA}) begin
      n_fail++; $display("FAIL rdw_read_first: q_a=%h q_b=%h expected aaaaaaaa aaaaaaaa", q0_a, q0_b);
    end
    idle();
    step();
    n_cmp++; if ({qv1_a, q1_a, qv1_b, q1_b} !== {1'b1, 32'h55555555, 1'b1, 32'h55555555}) begin
      n_fail++; $display("FAIL rdw_write_first: q_a=%h q_b=%h expected 55555555 55555555", q1_a, q1_b);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] dat [4];
    idle();
    for (int i = 0; i < 4; i++) begin
      dat[i] = $urandom;
      port_a(1, 4'hF, 4'(i), dat[i]);
      step();
    end
    idle(); step();
    for (int i = 0; i < 4; i++) begin
      port_a(0, 4'h0, 4'(i), '0);
      step();
      if (i == 0) begin
        n_cmp++; if (qv1_a !== 1'b0) begin n_fail++; $display("FAIL b2b_latency: qv=%b expected 0 one cycle after first read", qv1_a); end
      end else begin
        n_cmp++; if ({qv1_a, q1_a} !== {1'b1, dat[i-1]}) begin
          n_fail++; $display("FAIL b2b_data%0d: qv=%b q=%h expected 1/%h", i - 1, qv1_a, q1_a, dat[i-1]);
        end
      end
    end
    idle(); step();
    n_cmp++; if ({qv1_a, q1_a} !== {1'b1, dat[3]}) begin n_fail++; $display("FAIL b2b_data3: qv=%b q=%h expected 1/%h", qv1_a, q1_a, dat[3]); end
    step();
    n_cmp++; if ({qv1_a, q1_a} !== {1'b0, dat[3]}) begin n_fail++; $display("FAIL b2b_end: qv=%b q=%h expected 0/%h", qv1_a, q1_a, dat[3]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst    = ($urandom_range(0, 199) == 0);
      en_a   = ($urandom_range(0, 3) != 0); we_a = 1'($urandom); be_a = 4'($urandom);
      addr_a = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      d_a    = $urandom;
      en_b   = ($urandom_range(0, 3) != 0); we_b = 1'($urandom); be_b = 4'($urandom);
      addr_b = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(0, 3)) : 4'($urandom);
      d_b    = $urandom;
      step();
      n_cmp++; if (obs !== exp_vec) begin n_fail++; $display("FAIL random_cycle%0d: got %h expected %h", c, obs, exp_vec); end
    end
    rst = 0; idle();
  endtask

  task automatic test_reset_during_clear();
    int n;
    idle(); rst = 1; step();
    rst = 0; port_a(0, 4'h0, 4'd4, '0);
    for (int i = 0; i < 9; i++) begin
      step();
      n_cmp++; if (obs !== exp_vec) begin n_fail++; $display("FAIL clear_partial%0d: got %h expected %h", i, obs, exp_vec); end
    end
    rst = 1; step();
    n_cmp++; if ({q0_a, qv0_a, q1_a, qv1_a, busy0} !== {32'h0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL rst_in_clear: q0=%h qv0=%b q1=%h qv1=%b busy=%b expected 0 0 0 0 1", q0_a, qv0_a, q1_a, qv1_a, busy0);
    end
    rst = 0; n = 0;
    while (busy0 === 1'b1 && n < 40) begin
      step(); n++;
      n_cmp++; if (obs !== exp_vec) begin n_fail++; $display("FAIL clear_restart: got %h expected %h", obs, exp_vec); end
    end
    n_cmp++; if (n != 16) begin n_fail++; $display("FAIL restart_length: got %0d cycles expected 16", n); end
    port_a(0, 4'h0, 4'd2, '0); step(); step();
    n_cmp++; if ({qv0_a, q0_a, qv1_a, q1_a} !== {1'b1, 32'h0, 1'b1, 32'h0}) begin
      n_fail++; $display("FAIL cleared_word: q0=%h q1=%h expected 00000000 00000000", q0_a, q1_a);
    end
    idle(); step();
  endtask

  initial begin
    n_cmp = 0; n_fail = 0;
    rst = 1; idle();
    clear_left = 0; p_acc_a = 0; p_acc_b = 0; p_wf_a = '0; p_wf_b = '0;
    for (int i = 0; i < 16; i++) mm[i] = '0;
    #2;
    test_reset();
    test_byte_enable();
    test_collision();
    test_rdw();
    test_back_to_back();
    test_random();
    test_reset_during_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
